wb_stage: RTL
=============

# wb_stage

Write-back stage of the five-stage pipeline: holds the MEM/WB pipeline register and produces the single register-file write port. It captures the memory stage's ALU result, data-memory read value, destination register and control bits. It selects the write-back value and drives the register-file write and the forwarding/hazard observation outputs. It sits directly downstream of the memory stage and consumes `dataMem_out` and `ALU_res` from it.

## Interface
- `WIDTH`, default `` `MAX_LENGTH `` (32): data-path width.
- `REG_ADDR_W`, default 4: register index width (16 architectural registers).
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `freeze`  in  1  hold the pipeline register; no capture this cycle.
- `flush`  in  1  kill the incoming instruction; bubble enters the register.
- `valid_in`  in  1  memory stage holds a real instruction.
- `wb_en_in`  in  1  instruction writes a register.
- `memory_read_enabled`  in  1  instruction is a load; selects memory data.
- `dest_in`  in  REG_ADDR_W  destination register index.
- `ALU_res`  in  WIDTH  ALU result / effective address from the memory stage.
- `dataMem_out`  in  WIDTH  data-memory read value. Valid in the same cycle as `ALU_res`.
- `wb_en`  out  1  register-file write enable.
- `wb_dest`  out  REG_ADDR_W  register-file write index.
- `wb_value`  out  WIDTH  register-file write data.
- `wb_valid`  out  1  register holds a real instruction; used by the hazard unit.
- `retired_count`  out  32  retired-instruction count. Present only with `WB_RETIRE_CNT_EN`.

## Operation
- Register contents: `valid_q`, `wb_en_q`, `mem_rd_q`, `dest_q`, `alu_q`, `mem_q`.
- Per-edge priority, highest first: `reset`, then `flush`, then `freeze`, then load.
  - `reset`: all register fields are 0.
  - `flush`: `valid_q`=0 and `wb_en_q`=0. Data fields are don't-care and are driven to 0.
  - `freeze` (no flush): every field holds its value.
  - Otherwise, load: every field captures its input. A bubble (`valid_in`=0) is captured with `wb_en_q` forced to 0.
- Outputs are combinational from the register:
  - `wb_value` = `mem_rd_q` ? `mem_q` : `alu_q`.
  - `wb_en` = `valid_q` & `wb_en_q`.
  - `wb_dest` = `dest_q`.
  - `wb_valid` = `valid_q`.
- A held entry (under `freeze`) keeps asserting `wb_en`. The register file tolerates a repeated identical write.
- No arithmetic in the data path. Values pass through at full WIDTH with no truncation or extension.

## Timing
- Latency: 1 cycle. Inputs present before edge N appear on `wb_*` after edge N.
- Register-file write happens at edge N+1. The register file is write-first, so no extra forwarding is needed for a read in the same cycle.
- Reset values: `wb_en`=0, `wb_dest`=0, `wb_value`=0, `wb_valid`=0, `retired_count`=0.
- `reset` mid-stream discards the in-flight entry. The first capture after reset deasserts occurs on the next edge.
- `flush` and `freeze` together: flush wins and a bubble is inserted.
- Back-to-back freeze cycles: the entry holds indefinitely. Release resumes loading on the first edge with `freeze`=0.
- `memory_read_enabled`=1 with `wb_en_in`=0 (e.g. discarded load) produces no write. `wb_value` still shows `mem_q`.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - A 32-bit `retired_count` register and output port exist.
  - The counter increments by 1 on each edge that performs a load with `valid_in`=1.
  - It does not increment on freeze-hold, flush or reset.
  - It wraps from 0xFFFFFFFF to 0. Reset clears it to 0.
- `WB_RETIRE_CNT_EN` undefined: counter logic and port are absent. All other behaviour is identical.

## Test plan
- Reset: assert `reset` 2 cycles with random inputs -> all outputs 0. First load after release appears 1 cycle later.
- ALU write-back: `valid_in`=1, `wb_en_in`=1, `memory_read_enabled`=0, `dest_in`=5, `ALU_res`=0x0000_1234, `dataMem_out`=0xDEAD_BEEF -> next cycle `wb_en`=1, `wb_dest`=5, `wb_value`=0x1234.
- Load write-back: same stimulus with `memory_read_enabled`=1 -> `wb_value`=0xDEAD_BEEF, `wb_dest`=5.
- Freeze/flush priority:
  - Load entry A (dest 3), then freeze 3 cycles while inputs change to B (dest 7) -> outputs stay A for 3 cycles, then B one cycle after release.
  - `freeze`=1 with `flush`=1 -> bubble with `wb_en`=0 and `wb_valid`=0.
- Bubble: `valid_in`=0 with `wb_en_in`=1 -> `wb_en`=0, `wb_valid`=0.
- With `WB_RETIRE_CNT_EN`:
  - 10 valid loads, 2 bubbles, 3 freeze cycles and 1 flush -> `retired_count`=10.
  - Preload near wrap by driving 0xFFFFFFFF valid loads (or force), then one more valid load -> counter reads 0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register feeding the register-file write port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.

`ifndef MAX_LENGTH
`define MAX_LENGTH 32
`endif

module wb_stage #(
  parameter int WIDTH      = `MAX_LENGTH,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  wb_en_in,
  input  logic                  memory_read_enabled,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [WIDTH-1:0]      ALU_res,
  input  logic [WIDTH-1:0]      dataMem_out,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic [WIDTH-1:0]      wb_value,
  output logic                  wb_valid
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]           retired_count
`endif
);

  logic                  valid_q;
  logic                  wb_en_q;
  logic                  mem_rd_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [WIDTH-1:0]      alu_q;
  logic [WIDTH-1:0]      mem_q;

  // Priority: reset, flush, freeze (hold), then load.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q  <= 1'b0;
      wb_en_q  <= 1'b0;
      mem_rd_q <= 1'b0;
      dest_q   <= '0;
      alu_q    <= '0;
      mem_q    <= '0;
    end else if (!freeze) begin
      valid_q  <= valid_in;
      wb_en_q  <= valid_in & wb_en_in;
      mem_rd_q <= memory_read_enabled;
      dest_q   <= dest_in;
      alu_q    <= ALU_res;
      mem_q    <= dataMem_out;
    end
  end

  assign wb_value = mem_rd_q ? mem_q : alu_q;
  assign wb_en    = valid_q & wb_en_q;
  assign wb_dest  = dest_q;
  assign wb_valid = valid_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_count_q;

  // Counts only real instructions actually captured; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_count_q <= 32'd0;
    end else if (!flush && !freeze && valid_in) begin
      retired_count_q <= retired_count_q + 32'd1;
    end
  end

  assign retired_count = retired_count_q;
`endif

endmodule
